// File: rtl/stream_width_downsizer_if.sv
// -----------------------------------------------------------------------------
// stream_width_downsizer_if
//   Bundles the wide upstream (s_*) and narrow downstream (m_*) ready/valid
//   channels of stream_width_downsizer.
//   Parameters: IN_W  - upstream word width
//               OUT_W - downstream beat width
//   Signals:    s_valid/s_ready/s_data  - word channel into the downsizer
//               m_valid/m_ready/m_data/m_last - beat channel out of it
//   Modports:   slave  - downsizer view (consumes words, produces beats)
//               master - environment view (produces words, consumes beats)
// -----------------------------------------------------------------------------
interface stream_width_downsizer_if #(
    parameter int unsigned IN_W  = 32,
    parameter int unsigned OUT_W = 8
);
    logic             s_valid;
    logic             s_ready;
    logic [IN_W-1:0]  s_data;
    logic             m_valid;
    logic             m_ready;
    logic [OUT_W-1:0] m_data;
    logic             m_last;

    modport slave (
        input  s_valid, s_data, m_ready,
        output s_ready, m_valid, m_data, m_last
    );

    modport master (
        output s_valid, s_data, m_ready,
        input  s_ready, m_valid, m_data, m_last
    );
endinterface

// File: rtl/stream_width_downsizer.sv
// -----------------------------------------------------------------------------
// stream_width_downsizer
//   Accepts one IN_W-bit word per upstream handshake and replays it as
//   RATIO = IN_W/OUT_W beats of OUT_W bits, least-significant slice first,
//   flagging the final beat with m_last. Sustains one beat per cycle with no
//   bubble between consecutive words.
//
//   Ports:
//     clk        - clock, all state on posedge
//     rst_n      - asynchronous active-low reset
//     bus        - stream_width_downsizer_if.slave (s_* word in, m_* beat out)
//     busy       - a word is held with beats outstanding (same as m_valid)
//     word_cnt   - words accepted, saturating         (DWN_STATS_EN only)
//     stall_cnt  - cycles with m_valid && !m_ready     (DWN_STATS_EN only)
//     stats_clr  - synchronous clear of both counters  (DWN_STATS_EN only)
//
//   Optional feature macro: DWN_STATS_EN
// -----------------------------------------------------------------------------
module stream_width_downsizer #(
    parameter int unsigned IN_W  = 32,
    parameter int unsigned OUT_W = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    stream_width_downsizer_if.slave  bus,
    output logic                     busy
`ifdef DWN_STATS_EN
    ,
    output logic [31:0]              word_cnt,
    output logic [31:0]              stall_cnt,
    input  logic                     stats_clr
`endif
);
    localparam int unsigned RATIO = IN_W / OUT_W;
    localparam int unsigned IDX_W = (RATIO > 1) ? $clog2(RATIO) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(RATIO - 1);

    generate
        if ((IN_W % OUT_W) != 0 || RATIO < 2) begin : g_bad_cfg
            $error("stream_width_downsizer: IN_W must be a multiple of OUT_W with IN_W/OUT_W >= 2");
        end
    endgenerate

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_SEND  = 1'b1
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [IN_W-1:0]  r_hold;
    logic [IN_W-1:0]  w_hold_nxt;
    logic [IDX_W-1:0] r_idx;
    logic [IDX_W-1:0] w_idx_nxt;

    logic             w_m_valid;
    logic             w_at_last;
    logic             w_m_acc;
    logic             w_s_ready;
    logic             w_s_acc;
    logic [OUT_W-1:0] w_m_data;

    // State register and datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_EMPTY;
            r_hold  <= '0;
            r_idx   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_hold  <= w_hold_nxt;
            r_idx   <= w_idx_nxt;
        end
    end

    // Next-state / handshake logic
    always_comb begin
        w_m_valid   = (r_state == ST_SEND);
        w_at_last   = (r_idx == LAST_IDX);
        w_m_acc     = w_m_valid && bus.m_ready;
        // Refill in the same cycle the last beat leaves, so words chain
        // without a bubble; this is the m_ready -> s_ready combinational path.
        w_s_ready   = (r_state == ST_EMPTY) || (w_m_acc && w_at_last);
        w_s_acc     = bus.s_valid && w_s_ready;

        w_state_nxt = r_state;
        w_hold_nxt  = r_hold;
        w_idx_nxt   = r_idx;

        unique case (r_state)
            ST_EMPTY: begin
                if (w_s_acc) begin
                    w_state_nxt = ST_SEND;
                    w_hold_nxt  = bus.s_data;
                    w_idx_nxt   = '0;
                end
            end
            ST_SEND: begin
                if (w_m_acc) begin
                    if (!w_at_last) begin
                        w_idx_nxt = r_idx + IDX_W'(1);
                    end else if (w_s_acc) begin
                        w_hold_nxt = bus.s_data;
                        w_idx_nxt  = '0;
                    end else begin
                        // hold is intentionally left as-is; m_data is don't-care when idle
                        w_state_nxt = ST_EMPTY;
                        w_idx_nxt   = '0;
                    end
                end
            end
            default: begin
                w_state_nxt = ST_EMPTY;
                w_idx_nxt   = '0;
            end
        endcase
    end

    // Beat select: slice idx of the held word
    always_comb begin
        w_m_data = '0;
        for (int unsigned i = 0; i < RATIO; i++) begin
            if (r_idx == IDX_W'(i)) begin
                w_m_data = r_hold[i*OUT_W +: OUT_W];
            end
        end
    end

    assign bus.s_ready = w_s_ready;
    assign bus.m_valid = w_m_valid;
    assign bus.m_data  = w_m_data;
    assign bus.m_last  = w_m_valid && w_at_last;
    assign busy        = w_m_valid;

`ifdef DWN_STATS_EN
    logic [31:0] r_word_cnt;
    logic [31:0] r_stall_cnt;

    // Saturating counters; clear takes priority over a same-cycle increment
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_word_cnt  <= '0;
            r_stall_cnt <= '0;
        end else if (stats_clr) begin
            r_word_cnt  <= '0;
            r_stall_cnt <= '0;
        end else begin
            if (w_s_acc && (r_word_cnt != '1)) begin
                r_word_cnt <= r_word_cnt + 32'd1;
            end
            if (w_m_valid && !bus.m_ready && (r_stall_cnt != '1)) begin
                r_stall_cnt <= r_stall_cnt + 32'd1;
            end
        end
    end

    assign word_cnt  = r_word_cnt;
    assign stall_cnt = r_stall_cnt;
`endif

endmodule

// File: tb/tb_stream_width_downsizer.sv
// -----------------------------------------------------------------------------
// tb_stream_width_downsizer
//   Scoreboard bench for stream_width_downsizer (32->8 main instance plus a
//   24->8 instance). Accepted words are expanded into expected beats by
//   plain shifting and queued; a monitor pops and compares on each beat
//   handshake and also checks m_valid, busy and s_ready against the number
//   of beats still owed. Optional counters are checked when DWN_STATS_EN is
//   defined.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_stream_width_downsizer;

    typedef struct {
        logic [7:0] d;
        bit         last;
    } beat_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic busy, busy24;

    int unsigned n_chk = 0;
    int unsigned n_err = 0;

    beat_t       exp_q[$];
    bit          have_pend = 1'b0;
    logic [31:0] pend_word = '0;
    bit          prev_stall = 1'b0;
    logic [7:0]  prev_data = '0;

    always #5 clk = ~clk;

    stream_width_downsizer_if #(.IN_W(32), .OUT_W(8)) ifc ();
    stream_width_downsizer_if #(.IN_W(24), .OUT_W(8)) ifc24 ();

`ifdef DWN_STATS_EN
    logic [31:0] word_cnt, stall_cnt, word_cnt24, stall_cnt24;
    logic        stats_clr = 1'b0;
`endif

    stream_width_downsizer #(.IN_W(32), .OUT_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .bus(ifc), .busy(busy)
`ifdef DWN_STATS_EN
        , .word_cnt(word_cnt), .stall_cnt(stall_cnt), .stats_clr(stats_clr)
`endif
    );

    stream_width_downsizer #(.IN_W(24), .OUT_W(8)) dut24 (
        .clk(clk), .rst_n(rst_n), .bus(ifc24), .busy(busy24)
`ifdef DWN_STATS_EN
        , .word_cnt(word_cnt24), .stall_cnt(stall_cnt24), .stats_clr(1'b0)
`endif
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // One cycle of stimulus on the 32-bit instance. Expected beats of a word
    // accepted in the previous cycle are queued at the edge that commits it.
    task automatic drive(input bit sv, input logic [31:0] sd, input bit mr, output bit acc);
        @(posedge clk);
        if (have_pend) begin
            for (int k = 0; k < 4; k++) begin
                logic [31:0] sh;
                sh = pend_word >> (8 * k);
                exp_q.push_back('{d: sh[7:0], last: (k == 3)});
            end
            have_pend = 1'b0;
        end
        #1;
        ifc.s_valid = sv;
        ifc.s_data  = sd;
        ifc.m_ready = mr;
        @(negedge clk);
        acc = sv && ifc.s_ready && rst_n;
        if (acc) begin
            pend_word = sd;
            have_pend = 1'b1;
        end
    endtask

    task automatic send(input logic [31:0] w, input int unsigned pct_valid, input int unsigned pct_ready);
        bit acc = 1'b0;
        int unsigned n = 0;
        while (!acc && n < 64) begin
            drive($urandom_range(0, 99) < pct_valid, w, $urandom_range(0, 99) < pct_ready, acc);
            n++;
        end
        if (!acc) begin
            n_chk++;
            n_err++;
            $display("FAIL send_timeout: got no accept expected accept of %08h", w);
        end
    endtask

    task automatic idle(input int unsigned n, input bit mr);
        bit acc;
        for (int unsigned i = 0; i < n; i++) drive(1'b0, 32'h0, mr, acc);
    endtask

    task automatic drain();
        int unsigned n = 0;
        while ((exp_q.size() != 0 || have_pend) && n < 100) begin
            idle(1, 1'b1);
            n++;
        end
        idle(1, 1'b1);
        chk("drain_empty", 64'(exp_q.size()), 64'd0);
    endtask

    // Monitor: compares the 32-bit instance against the beat queue
    always @(negedge clk) begin
        if (rst_n) begin
            chk("m_valid", 64'(ifc.m_valid), 64'(exp_q.size() != 0));
            chk("busy", 64'(busy), 64'(ifc.m_valid));
            chk("s_ready", 64'(ifc.s_ready),
                64'((exp_q.size() == 0) || (ifc.m_ready && exp_q.size() == 1)));
            if (prev_stall) chk("stall_stable", 64'(ifc.m_data), 64'(prev_data));
            if (ifc.m_valid && exp_q.size() != 0) begin
                chk("m_data", 64'(ifc.m_data), 64'(exp_q[0].d));
                chk("m_last", 64'(ifc.m_last), 64'(exp_q[0].last));
                if (ifc.m_ready) void'(exp_q.pop_front());
            end else if (!ifc.m_valid) begin
                chk("m_last_idle", 64'(ifc.m_last), 64'd0);
            end
            prev_stall = ifc.m_valid && !ifc.m_ready;
            prev_data  = ifc.m_data;
        end else begin
            prev_stall = 1'b0;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit acc;
        ifc.s_valid = 1'b0; ifc.s_data = '0; ifc.m_ready = 1'b0;
        ifc24.s_valid = 1'b0; ifc24.s_data = '0; ifc24.m_ready = 1'b0;

        // Reset state
        #23;
        chk("rst_m_valid", 64'(ifc.m_valid), 64'd0);
        chk("rst_m_last", 64'(ifc.m_last), 64'd0);
        chk("rst_m_data", 64'(ifc.m_data), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_s_ready", 64'(ifc.s_ready), 64'd1);
        @(posedge clk); #1 rst_n = 1'b1;

        // Single word, full rate
        send(32'hA1B2C3D4, 100, 100);
        idle(6, 1'b1);

        // Back-to-back words, s_valid and m_ready held high
        drive(1'b1, 32'h03020100, 1'b1, acc);
        while (!acc) drive(1'b1, 32'h03020100, 1'b1, acc);
        acc = 1'b0;
        for (int i = 0; i < 8 && !acc; i++) drive(1'b1, 32'h07060504, 1'b1, acc);
        chk("b2b_accept", 64'(acc), 64'd1);
        idle(6, 1'b1);

        // Stall while second beat is presented
        send(32'hA1B2C3D4, 100, 100);
        idle(1, 1'b1);
        idle(3, 1'b0);
        idle(5, 1'b1);

        // Reset after two beats
        send(32'hDEADBEEF, 100, 100);
        idle(2, 1'b1);
        @(posedge clk); #1;
        rst_n = 1'b0;
        exp_q.delete();
        have_pend = 1'b0;
        ifc.s_valid = 1'b0;
        #1;
        chk("midrst_m_valid", 64'(ifc.m_valid), 64'd0);
        chk("midrst_busy", 64'(busy), 64'd0);
        chk("midrst_s_ready", 64'(ifc.s_ready), 64'd1);
        @(posedge clk); #1 rst_n = 1'b1;
        send(32'h11223344, 100, 100);
        idle(6, 1'b1);

`ifdef DWN_STATS_EN
        @(posedge clk); #1 stats_clr = 1'b1;
        @(posedge clk); #1 stats_clr = 1'b0;
        send(32'h0BADF00D, 100, 100);
        idle(3, 1'b0);
        idle(3, 1'b1);
        drive(1'b1, 32'hCAFEF00D, 1'b1, acc);
        chk("stats_acc2", 64'(acc), 64'd1);
        idle(5, 1'b1);
        chk("word_cnt", 64'(word_cnt), 64'd2);
        chk("stall_cnt", 64'(stall_cnt), 64'd3);
        stats_clr = 1'b1;
        drive(1'b1, 32'h12345678, 1'b1, acc);
        chk("clr_acc", 64'(acc), 64'd1);
        @(posedge clk); #1 stats_clr = 1'b0;
        chk("clr_word_cnt", 64'(word_cnt), 64'd0);
        chk("clr_stall_cnt", 64'(stall_cnt), 64'd0);
        have_pend = 1'b1;
        pend_word = 32'h12345678;
        // the clear cycle above already committed this word; queue it before the next beat check
        for (int k = 0; k < 4; k++) begin
            logic [31:0] sh;
            sh = pend_word >> (8 * k);
            exp_q.push_back('{d: sh[7:0], last: (k == 3)});
        end
        have_pend = 1'b0;
        idle(6, 1'b1);
`endif

        // Randomised traffic
        for (int n = 0; n < 200; n++) send($urandom, 75, 70);
        drain();

        // 24-bit instance: three beats per word
        @(posedge clk); #1;
        ifc24.s_valid = 1'b1; ifc24.s_data = 24'hABCDEF; ifc24.m_ready = 1'b1;
        @(negedge clk);
        chk("w24_s_ready", 64'(ifc24.s_ready), 64'd1);
        @(posedge clk); #1 ifc24.s_valid = 1'b0;
        for (int k = 0; k < 3; k++) begin
            logic [23:0] w24;
            w24 = 24'hABCDEF >> (8 * k);
            @(negedge clk);
            chk("w24_m_valid", 64'(ifc24.m_valid), 64'd1);
            chk("w24_m_data", 64'(ifc24.m_data), 64'(w24[7:0]));
            chk("w24_m_last", 64'(ifc24.m_last), 64'(k == 2));
        end
        @(negedge clk);
        chk("w24_done", 64'(ifc24.m_valid), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_err);
        $finish;
    end

endmodule
